// File: rtl/bip_pkg.sv
// Shared widths, FSM state encoding and decoder select encodings for the BIP datapath.
package bip_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } bip_state_e;

    localparam logic [1:0] SEL_A_RAM  = 2'd0;
    localparam logic [1:0] SEL_A_IMM  = 2'd1;
    localparam logic [1:0] SEL_A_ALU  = 2'd2;
    localparam logic [1:0] SEL_A_RSVD = 2'd3;

    localparam logic SEL_B_RAM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    // Immediates come from the instruction operand field, always treated as signed.
    function automatic logic [DATA_W-1:0] sign_ext(input logic [ADDR_W-1:0] imm);
        return {{(DATA_W-ADDR_W){imm[ADDR_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/bip_datapath_if.sv
// Data RAM bus between the BIP datapath (master) and the data memory (slave).
interface bip_datapath_if;
    import bip_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/bip_alu.sv
// Combinational 16-bit add/subtract with signed-overflow detection.
module bip_alu
    import bip_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf
);

    always_comb begin
        o_result = i_op ? (i_a + i_b) : (i_a - i_b);
        // Overflow when operand signs make the result sign impossible for the operation.
        if (i_op) begin
            o_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (o_result[DATA_W-1] != i_a[DATA_W-1]);
        end else begin
            o_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (o_result[DATA_W-1] != i_a[DATA_W-1]);
        end
    end

endmodule

// File: rtl/bip_datapath.sv
// BIP accumulator datapath with a stalling data-RAM handshake.
// Optional status flags (flag_z/flag_n/flag_v) are built when BIP_DP_FLAGS_EN is defined.
module bip_datapath
    import bip_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel_a,
    input  logic              sel_b,
    input  logic              wr_acc,
    input  logic              op,
    input  logic              wr_ram,
    input  logic              rd_ram,
    input  logic [ADDR_W-1:0] operand,
    bip_datapath_if.master    mem,
    output logic              stall,
    output logic [DATA_W-1:0] acc
`ifdef BIP_DP_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v
`endif
);

    bip_state_e        r_state;
    bip_state_e        w_next_state;

    logic [1:0]        r_sel_a;
    logic              r_sel_b;
    logic              r_op;
    logic              r_wr_acc;
    logic              r_we;
    logic [ADDR_W-1:0] r_operand;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_acc;

    logic              w_idle;
    logic              w_issue;
    logic              w_sel_b;
    logic              w_op;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_ovf;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_acc_load;
    logic              w_acc_from_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Requests are driven straight from the decoder in IDLE, then from the latched copy.
    always_comb begin
        w_next_state  = r_state;
        w_issue       = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        stall         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wr_ram) begin
                    w_next_state  = ST_WR_WAIT;
                    w_issue       = 1'b1;
                    mem.mem_req   = 1'b1;
                    mem.mem_we    = 1'b1;
                    mem.mem_addr  = operand;
                    mem.mem_wdata = r_acc;
                    stall         = 1'b1;
                end else if (rd_ram) begin
                    w_next_state  = ST_RD_WAIT;
                    w_issue       = 1'b1;
                    mem.mem_req   = 1'b1;
                    mem.mem_addr  = operand;
                    stall         = 1'b1;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = r_we;
                mem.mem_addr  = r_operand;
                mem.mem_wdata = r_wdata;
                stall         = !mem.mem_ack;
                if (mem.mem_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // Reset must silence the bus even while the decoder is still requesting.
        if (!rst_n) begin
            w_issue       = 1'b0;
            mem.mem_req   = 1'b0;
            mem.mem_we    = 1'b0;
            mem.mem_addr  = '0;
            mem.mem_wdata = '0;
            stall         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_a   <= SEL_A_RAM;
            r_sel_b   <= SEL_B_RAM;
            r_op      <= 1'b0;
            r_wr_acc  <= 1'b0;
            r_we      <= 1'b0;
            r_operand <= '0;
            r_wdata   <= '0;
        end else if (w_issue) begin
            r_sel_a   <= sel_a;
            r_sel_b   <= sel_b;
            r_op      <= op;
            r_wr_acc  <= wr_acc;
            r_we      <= wr_ram;
            r_operand <= operand;
            r_wdata   <= mem.mem_wdata;
        end
    end

    assign w_idle    = (r_state == ST_IDLE);
    assign w_sel_b   = w_idle ? sel_b   : r_sel_b;
    assign w_op      = w_idle ? op      : r_op;
    assign w_operand = w_idle ? operand : r_operand;
    assign w_imm     = sign_ext(w_operand);
    assign w_alu_b   = (w_sel_b == SEL_B_IMM) ? w_imm : mem.mem_rdata;

    bip_alu u_alu (
        .i_a      (r_acc),
        .i_b      (w_alu_b),
        .i_op     (w_op),
        .o_result (w_alu_result),
        .o_ovf    (w_alu_ovf)
    );

    // Unknown or reserved selects fall to the default arms, so acc simply holds.
    always_comb begin
        w_acc_load     = 1'b0;
        w_acc_from_alu = 1'b0;
        w_acc_next     = r_acc;
        if (w_idle) begin
            if (!rd_ram && !wr_ram && wr_acc) begin
                case (sel_a)
                    SEL_A_IMM: begin
                        w_acc_load = 1'b1;
                        w_acc_next = w_imm;
                    end
                    SEL_A_ALU: begin
                        w_acc_load     = 1'b1;
                        w_acc_from_alu = 1'b1;
                        w_acc_next     = w_alu_result;
                    end
                    default: begin
                    end
                endcase
            end
        end else if ((r_state == ST_RD_WAIT) && mem.mem_ack && r_wr_acc) begin
            case (r_sel_a)
                SEL_A_RAM: begin
                    w_acc_load = 1'b1;
                    w_acc_next = mem.mem_rdata;
                end
                SEL_A_IMM: begin
                    w_acc_load = 1'b1;
                    w_acc_next = w_imm;
                end
                SEL_A_ALU: begin
                    w_acc_load     = 1'b1;
                    w_acc_from_alu = 1'b1;
                    w_acc_next     = w_alu_result;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_acc_load) begin
            r_acc <= w_acc_next;
        end
    end

    assign acc = r_acc;

`ifdef BIP_DP_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;
    logic r_flag_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (w_acc_load) begin
            r_flag_z <= (w_acc_next == '0);
            r_flag_n <= w_acc_next[DATA_W-1];
            r_flag_v <= w_acc_from_alu & w_alu_ovf;
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_v = r_flag_v;
`else
    logic w_unused_flags;
    assign w_unused_flags = w_alu_ovf | w_acc_from_alu;
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// Scoreboard bench for bip_datapath: directed cycles push expectations, a negedge monitor checks them.
// Flag checks are compiled in when BIP_DP_FLAGS_EN is defined.
module tb_bip_datapath;

    logic        clk;
    logic        rst_n;
    logic [1:0]  selA;
    logic        selB;
    logic        wrAcc;
    logic        op;
    logic        wrRam;
    logic        rdRam;
    logic [10:0] operand;
    logic        stall;
    logic [15:0] acc;
`ifdef BIP_DP_FLAGS_EN
    logic        flagZ;
    logic        flagN;
    logic        flagV;
`endif

    bip_datapath_if memBus();

    bip_datapath dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel_a   (selA),
        .sel_b   (selB),
        .wr_acc  (wrAcc),
        .op      (op),
        .wr_ram  (wrRam),
        .rd_ram  (rdRam),
        .operand (operand),
        .mem     (memBus),
        .stall   (stall),
        .acc     (acc)
`ifdef BIP_DP_FLAGS_EN
        ,
        .flag_z  (flagZ),
        .flag_n  (flagN),
        .flag_v  (flagV)
`endif
    );

    typedef struct {
        string       name;
        logic        inReset;
        logic [15:0] acc;
        logic        stall;
        logic        req;
        logic        we;
        logic [10:0] addr;
        logic [15:0] wdata;
        logic        chkFlags;
        logic        z;
        logic        n;
        logic        v;
    } expT;

    expT expQ[$];
    expT cur;
    int  errors = 0;
    int  checks = 0;
    logic fChk = 1'b0;
    logic fZ = 1'b0;
    logic fN = 1'b0;
    logic fV = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string nm, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, actual, required);
        end
    endtask

    task automatic expectFlags(input logic z, input logic n, input logic v);
        fChk = 1'b1;
        fZ = z;
        fN = n;
        fV = v;
    endtask

    // Drive one cycle of decoder/RAM inputs and queue what the outputs must show in that cycle.
    task automatic applyStimulus(input string nm, input logic rn, input logic [1:0] sa, input logic sb,
                                 input logic wa, input logic o, input logic wr, input logic rd,
                                 input logic [10:0] opd, input logic ack, input logic [15:0] rdata,
                                 input logic [15:0] eAcc, input logic eStall, input logic eReq,
                                 input logic eWe, input logic [10:0] eAddr, input logic [15:0] eWdata);
        expT e;
        @(posedge clk);
        #1;
        rst_n = rn;
        selA = sa;
        selB = sb;
        wrAcc = wa;
        op = o;
        wrRam = wr;
        rdRam = rd;
        operand = opd;
        memBus.mem_ack = ack;
        memBus.mem_rdata = rdata;
        e.name = nm;
        e.inReset = !rn;
        e.acc = eAcc;
        e.stall = eStall;
        e.req = eReq;
        e.we = eWe;
        e.addr = eAddr;
        e.wdata = eWdata;
        e.chkFlags = fChk;
        e.z = fZ;
        e.n = fN;
        e.v = fV;
        fChk = 1'b0;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            checkOutput({cur.name, ".acc"}, 32'(acc), 32'(cur.acc));
            checkOutput({cur.name, ".stall"}, 32'(stall), 32'(cur.stall));
            checkOutput({cur.name, ".mem_req"}, 32'(memBus.mem_req), 32'(cur.req));
            if (cur.req || cur.inReset) begin
                checkOutput({cur.name, ".mem_we"}, 32'(memBus.mem_we), 32'(cur.we));
                checkOutput({cur.name, ".mem_addr"}, 32'(memBus.mem_addr), 32'(cur.addr));
            end
            if (cur.we || cur.inReset) begin
                checkOutput({cur.name, ".mem_wdata"}, 32'(memBus.mem_wdata), 32'(cur.wdata));
            end
`ifdef BIP_DP_FLAGS_EN
            if (cur.chkFlags) begin
                checkOutput({cur.name, ".flag_z"}, 32'(flagZ), 32'(cur.z));
                checkOutput({cur.name, ".flag_n"}, 32'(flagN), 32'(cur.n));
                checkOutput({cur.name, ".flag_v"}, 32'(flagV), 32'(cur.v));
            end
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        selA = 2'd0;
        selB = 1'b0;
        wrAcc = 1'b0;
        op = 1'b0;
        wrRam = 1'b0;
        rdRam = 1'b0;
        operand = 11'h000;
        memBus.mem_ack = 1'b0;
        memBus.mem_rdata = 16'h0000;

        //             name            rn sa sb wa op wr rd operand  ack rdata     eAcc      eSt eRq eWe eAddr    eWdata
        expectFlags(1'b0, 1'b0, 1'b0);
        applyStimulus("reset",         0, 0, 0, 0, 0, 0, 1, 11'h055, 0, 16'h0000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("ldi_7ff",       1, 1, 0, 1, 0, 0, 0, 11'h7FF, 0, 16'h0000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("ldi_result",    1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 16'h0000, 16'hFFFF, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("ldi_5",         1, 1, 0, 1, 0, 0, 0, 11'h005, 0, 16'h0000, 16'hFFFF, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("addi_3",        1, 2, 1, 1, 1, 0, 0, 11'h003, 0, 16'h0000, 16'h0005, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("subi_10",       1, 2, 1, 1, 0, 0, 0, 11'h00A, 0, 16'h0000, 16'h0008, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("addi_neg",      1, 2, 1, 1, 1, 0, 0, 11'h400, 0, 16'h0000, 16'hFFFE, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("sel_rsvd",      1, 3, 0, 1, 0, 0, 0, 11'h123, 0, 16'h0000, 16'hFBFE, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("wracc_off",     1, 1, 0, 0, 0, 0, 0, 11'h111, 0, 16'h0000, 16'hFBFE, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("hold",          1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 16'h0000, 16'hFBFE, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("ld_issue",      1, 0, 0, 1, 0, 0, 1, 11'h010, 0, 16'h0000, 16'hFBFE, 1, 1, 0, 11'h010, 16'h0000);
        applyStimulus("ld_wait1",      1, 1, 0, 0, 0, 0, 0, 11'h7AA, 0, 16'hDEAD, 16'hFBFE, 1, 1, 0, 11'h010, 16'h0000);
        applyStimulus("ld_wait2",      1, 1, 0, 0, 0, 0, 0, 11'h7AA, 0, 16'hDEAD, 16'hFBFE, 1, 1, 0, 11'h010, 16'h0000);
        applyStimulus("ld_ack",        1, 1, 0, 0, 0, 0, 0, 11'h7AA, 1, 16'h1234, 16'hFBFE, 0, 1, 0, 11'h010, 16'h0000);
        applyStimulus("ld_result",     1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 16'h0000, 16'h1234, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("addm_issue",    1, 2, 0, 1, 1, 0, 1, 11'h011, 0, 16'h0000, 16'h1234, 1, 1, 0, 11'h011, 16'h0000);
        applyStimulus("addm_ack",      1, 0, 0, 0, 0, 0, 0, 11'h000, 1, 16'h0100, 16'h1234, 0, 1, 0, 11'h011, 16'h0000);
        applyStimulus("ldabcd_issue",  1, 0, 0, 1, 0, 0, 1, 11'h012, 0, 16'h0000, 16'h1334, 1, 1, 0, 11'h012, 16'h0000);
        applyStimulus("ldabcd_ack",    1, 0, 0, 0, 0, 0, 0, 11'h000, 1, 16'hABCD, 16'h1334, 0, 1, 0, 11'h012, 16'h0000);
        applyStimulus("sto_issue",     1, 1, 0, 1, 0, 1, 1, 11'h020, 0, 16'h0000, 16'hABCD, 1, 1, 1, 11'h020, 16'hABCD);
        applyStimulus("sto_wait",      1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 16'h0000, 16'hABCD, 1, 1, 1, 11'h020, 16'hABCD);
        applyStimulus("sto_ack",       1, 0, 0, 0, 0, 0, 0, 11'h000, 1, 16'h0000, 16'hABCD, 0, 1, 1, 11'h020, 16'hABCD);
        applyStimulus("b2b_issue",     1, 0, 0, 0, 0, 0, 1, 11'h033, 0, 16'h0000, 16'hABCD, 1, 1, 0, 11'h033, 16'h0000);
        applyStimulus("b2b_ack",       1, 0, 0, 0, 0, 0, 0, 11'h000, 1, 16'h5555, 16'hABCD, 0, 1, 0, 11'h033, 16'h0000);
        applyStimulus("idle_ack",      1, 0, 0, 0, 0, 0, 0, 11'h000, 1, 16'h0000, 16'hABCD, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("idle_hold",     1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 16'h0000, 16'hABCD, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("rst_issue",     1, 0, 0, 1, 0, 0, 1, 11'h044, 0, 16'h0000, 16'hABCD, 1, 1, 0, 11'h044, 16'h0000);
        expectFlags(1'b0, 1'b0, 1'b0);
        applyStimulus("rst_mid",       0, 0, 0, 1, 0, 0, 1, 11'h044, 0, 16'h0000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("late_ack",      1, 0, 0, 0, 0, 0, 0, 11'h000, 1, 16'h9999, 16'h0000, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("post_rst",      1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 16'h0000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000);
        applyStimulus("ld7fff_issue",  1, 0, 0, 1, 0, 0, 1, 11'h050, 0, 16'h0000, 16'h0000, 1, 1, 0, 11'h050, 16'h0000);
        applyStimulus("ld7fff_ack",    1, 0, 0, 0, 0, 0, 0, 11'h000, 1, 16'h7FFF, 16'h0000, 0, 1, 0, 11'h050, 16'h0000);
        expectFlags(1'b0, 1'b0, 1'b0);
        applyStimulus("add_ovf",       1, 2, 1, 1, 1, 0, 0, 11'h001, 0, 16'h0000, 16'h7FFF, 0, 0, 0, 11'h000, 16'h0000);
        expectFlags(1'b0, 1'b1, 1'b1);
        applyStimulus("ldi_zero",      1, 1, 0, 1, 0, 0, 0, 11'h000, 0, 16'h0000, 16'h8000, 0, 0, 0, 11'h000, 16'h0000);
        expectFlags(1'b1, 1'b0, 1'b0);
        applyStimulus("zero_result",   1, 0, 0, 0, 0, 0, 0, 11'h000, 0, 16'h0000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000);

        @(negedge clk);
        #1;
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bip_datapath.md
BIP_DATAPATH -- requirements
Module: bip_datapath

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-002 SHALL have these decoder control inputs:
- sel_a  input  2  accumulator source: 0 RAM data, 1 immediate, 2 ALU result, 3 reserved.
- sel_b  input  1  ALU operand B: 0 RAM data, 1 immediate.
- wr_acc  input  1  accumulator write enable.
- op  input  1  1 add, 0 subtract.
- wr_ram  input  1  store accumulator to RAM.
- rd_ram  input  1  read RAM operand.
REQ-003 SHALL have these data and memory ports:
- operand  input  11  instruction operand: address or immediate.
- mem_addr  output  11  data RAM address.
- mem_wdata  output  16  data RAM write data.
- mem_rdata  input  16  data RAM read data, valid while mem_ack=1.
- mem_req  output  1  RAM request.
- mem_we  output  1  RAM write qualifier.
- mem_ack  input  1  RAM completion, one cycle.
REQ-004 SHALL have these status outputs:
- stall  output  1  holds PC; when 1, the upstream decoder's wr_pc must be gated.
- acc  output  16  accumulator value.

Function
REQ-005 SHALL sign-extend operand[10] to 16 bits for every immediate use.
REQ-006 SHALL compute ALU = acc + B when op=1 and acc - B when op=0, 16-bit two's complement with wrap and no saturation.
REQ-007 SHALL implement an FSM with states IDLE, RD_WAIT and WR_WAIT; reset state is IDLE.
REQ-008 In IDLE with wr_ram=1, SHALL assert mem_req=1, mem_we=1, mem_addr=operand, mem_wdata=acc, and enter WR_WAIT; rd_ram is ignored when wr_ram=1.
REQ-009 In IDLE with rd_ram=1 and wr_ram=0, SHALL assert mem_req=1, mem_we=0, mem_addr=operand, and enter RD_WAIT.
REQ-010 On leaving IDLE, SHALL latch sel_a, sel_b, op, wr_acc, operand and mem_wdata; the outputs hold these latched values until the request completes.
REQ-011 In IDLE with rd_ram=0, wr_ram=0 and wr_acc=1, SHALL load acc at the next edge from sel_a (1 immediate, 2 ALU with B per sel_b); no memory access occurs.
REQ-012 In RD_WAIT on mem_ack=1, SHALL load acc using the latched controls with mem_rdata as the RAM source, provided the latched wr_acc=1; then return to IDLE.
REQ-013 In WR_WAIT on mem_ack=1, SHALL return to IDLE; acc is unchanged.
REQ-014 SHALL drive stall = (state != IDLE) OR (state == IDLE AND (rd_ram OR wr_ram)), masked to 0 in the cycle mem_ack=1; a zero-wait-state RAM therefore costs exactly one stall cycle.
REQ-015 SHALL deassert mem_req in the cycle after mem_ack; a new request may issue from IDLE in that same cycle.
REQ-016 SHALL ignore mem_ack while in IDLE.
REQ-017 SHALL leave acc unchanged when sel_a=3 or when wr_acc=0; X on unused controls SHALL NOT propagate into acc.

Reset
REQ-018 On rst_n=0, SHALL immediately set acc=0, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 and stall=0, aborting any outstanding transaction.

Configuration
REQ-019 With BIP_DP_FLAGS_EN defined, SHALL add outputs flag_z, flag_n and flag_v (1-bit each), registered on every acc write: zero, bit 15, and signed overflow of the ALU result (0 for non-ALU loads). All three reset to 0.
REQ-020 Without BIP_DP_FLAGS_EN, these ports and their logic SHALL be absent.

Structure
REQ-021 SHALL place data width (16), address width (11), the FSM state enum and the sel_a/sel_b encodings in shared package bip_pkg.
REQ-022 SHALL put add/sub and overflow in combinational sub-module bip_alu.

Verification
REQ-023 SHALL cover these directed scenarios:
- Reset, then LDI: sel_a=1, wr_acc=1, operand=0x7FF -> acc=0xFFFF next edge, stall=0.
- ADDI: acc=5, sel_a=2, sel_b=1, op=1, operand=3 -> acc=8; SUBI operand=10 -> acc=0xFFFE.
- LD: rd_ram=1, operand=0x010, ack after 3 cycles, mem_rdata=0x1234 -> stall high 3 cycles, acc=0x1234 on the ack edge, mem_addr=0x010 held throughout.
- STO: acc=0xABCD, wr_ram=1, operand=0x020, ack after 1 cycle -> mem_we=1, mem_wdata=0xABCD, acc unchanged.
- rst_n asserted during RD_WAIT -> mem_req=0 and acc=0 immediately; a late mem_ack is ignored.
- With BIP_DP_FLAGS_EN: ADD 0x7FFF+1 -> acc=0x8000, flag_v=1, flag_n=1, flag_z=0.
